// File: rtl/psum_stream_tx.sv
// -----------------------------------------------------------------------------
// psum_stream_tx
//
// Serialises one wide psum frame into an AXI4-Stream master, LSB word first.
// A frame is captured whole on psum_valid && psum_ready. It is then shifted out
// one C_M_AXIS_TDATA_WIDTH beat at a time. M_AXIS_TLAST marks the final beat.
//
// Optional feature (macro PSUM_TX_DOUBLE_BUFFER_EN):
//   When the macro is defined, a one-frame pending buffer lets the next frame
//   be accepted while the current one is streaming. Frames then leave
//   back-to-back with no idle cycle.
//   When the macro is undefined, psum_ready is only high in IDLE. Consecutive
//   frames are then separated by exactly one idle cycle.
//
// Ports
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   psum_in        PSUM_WIDTH-bit frame from the data path
//   psum_valid     psum_in holds a frame
//   psum_ready     block can accept a frame this cycle
//   M_AXIS_TVALID  registered beat valid
//   M_AXIS_TDATA   registered beat data
//   M_AXIS_TSTRB   constant all-ones byte strobes
//   M_AXIS_TLAST   registered last-beat flag
//   M_AXIS_TREADY  downstream sink accepts the beat
//   busy           a frame is being streamed (state == SEND)
//   frame_count    completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module psum_stream_tx #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int PSUM_WIDTH           = 1280
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PSUM_WIDTH-1:0]             psum_in,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic [15:0]                       frame_count
);

  localparam int W     = C_M_AXIS_TDATA_WIDTH;
  localparam int BEATS = PSUM_WIDTH / W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [PSUM_WIDTH-1:0]   frame_sr;     // beats still to be presented after the current one
  logic [CNT_W-1:0]        beat_cnt;
  logic                    tvalid_r;
  logic                    tlast_r;
  logic [W-1:0]            tdata_r;
  logic [15:0]             frame_cnt_r;

  logic                    accept;
  logic                    beat_hs;
  logic                    last_hs;
  logic                    load_en;
  logic [PSUM_WIDTH-1:0]   load_frame;

`ifdef PSUM_TX_DOUBLE_BUFFER_EN
  logic                    pend_vld;
  logic [PSUM_WIDTH-1:0]   pend_data;

  assign psum_ready = (state == IDLE) || !pend_vld;
`else
  assign psum_ready = (state == IDLE);
`endif

  assign accept  = psum_valid && psum_ready;
  assign beat_hs = tvalid_r && M_AXIS_TREADY;
  assign last_hs = beat_hs && (beat_cnt == LAST_BEAT);

  // Pick the frame that enters the shift register this edge, if any. On a
  // last-beat handshake, the pending frame wins over a fresh accept. A fresh
  // accept cannot happen while pending is full anyway, because psum_ready is
  // low then.
  always_comb begin
    load_en    = 1'b0;
    load_frame = psum_in;
    if (state == IDLE) begin
      load_en = accept;
    end
`ifdef PSUM_TX_DOUBLE_BUFFER_EN
    else if (last_hs) begin
      if (pend_vld) begin
        load_en    = 1'b1;
        load_frame = pend_data;
      end else if (accept) begin
        load_en = 1'b1;
      end
    end
`endif
  end

  // ---- output register stage: beat presented on M_AXIS_* ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tdata_r     <= '0;
      frame_cnt_r <= '0;
`ifdef PSUM_TX_DOUBLE_BUFFER_EN
      pend_vld    <= 1'b0;
`endif
    end else begin
      if (last_hs) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end

      if (load_en) begin
        state    <= SEND;
        tvalid_r <= 1'b1;
        tdata_r  <= load_frame[W-1:0];
        frame_sr <= load_frame >> W;
        beat_cnt <= '0;
        tlast_r  <= (BEATS == 1);
      end else if (last_hs) begin
        state    <= IDLE;
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
        beat_cnt <= '0;
      end else if (beat_hs) begin
        // Only advance on a handshake, so stalled beats hold steady.
        tdata_r  <= frame_sr[W-1:0];
        frame_sr <= frame_sr >> W;
        beat_cnt <= beat_cnt + CNT_W'(1);
        tlast_r  <= ((beat_cnt + CNT_W'(1)) == LAST_BEAT);
      end

`ifdef PSUM_TX_DOUBLE_BUFFER_EN
      if (last_hs && pend_vld) begin
        pend_vld <= 1'b0;
      end else if ((state == SEND) && accept && !last_hs) begin
        pend_vld  <= 1'b1;
        pend_data <= psum_in;
      end
`endif
    end
  end

  assign M_AXIS_TVALID = tvalid_r;
  assign M_AXIS_TDATA  = tdata_r;
  assign M_AXIS_TLAST  = tlast_r;
  assign M_AXIS_TSTRB  = '1;
  assign busy          = (state == SEND);
  assign frame_count   = frame_cnt_r;

endmodule

// File: tb/tb_psum_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_psum_stream_tx
//
// Directed bench for psum_stream_tx at its default widths (32-bit beats,
// 40-beat frames). Inputs are driven and outputs are sampled on the falling
// edge. Expected beats come from the frame pattern the bench itself builds.
// The back-to-back test follows PSUM_TX_DOUBLE_BUFFER_EN, matching the RTL
// build.
// -----------------------------------------------------------------------------
module tb_psum_stream_tx;

  localparam int W  = 32;
  localparam int PW = 1280;
  localparam int NB = 40;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PW-1:0]   psum_in = '0;
  logic            psum_valid = 1'b0;
  logic            psum_ready;
  logic            M_AXIS_TVALID;
  logic [W-1:0]    M_AXIS_TDATA;
  logic [W/8-1:0]  M_AXIS_TSTRB;
  logic            M_AXIS_TLAST;
  logic            M_AXIS_TREADY = 1'b0;
  logic            busy;
  logic [15:0]     frame_count;

  psum_stream_tx #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .PSUM_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .psum_in(psum_in),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] got_data [0:127];
  logic         got_last [0:127];
  int           s_cycles;
  int           s_gaps;
  int           s_ready_busy;

  logic [PW-1:0] f1, fa, fb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word k of a frame is {hi, k+base}.
  function automatic logic [W-1:0] word(input logic [23:0] hi, input int base, input int k);
    return {hi, 8'(k + base)};
  endfunction

  function automatic logic [PW-1:0] mk(input logic [23:0] hi, input int base);
    logic [PW-1:0] f;
    f = '0;
    for (int k = 0; k < NB; k++) f[k*W +: W] = word(hi, base, k);
    return f;
  endfunction

  // Runs from the current falling edge until nbeat handshakes are collected.
  // It optionally stalls TREADY on even cycles. It optionally offers a second
  // frame until the DUT takes it. Each stalled beat is checked for stability.
  task automatic stream(input int nbeat, input bit stall, input bit offer, input logic [PW-1:0] nxt);
    int           got;
    int           c;
    bit           want;
    bit           prev_stall;
    logic [W-1:0] prev_d;
    logic         prev_l;
    got = 0; c = 0; want = offer; prev_stall = 0; prev_d = '0; prev_l = 0;
    s_gaps = 0; s_ready_busy = 0;
    while (got < nbeat && c < 400) begin
      M_AXIS_TREADY = stall ? ((c % 2) == 1) : 1'b1;
      if (want) begin
        psum_in    = nxt;
        psum_valid = 1'b1;
        if (psum_ready) want = 0;
      end else begin
        psum_valid = 1'b0;
      end
      if (prev_stall) begin
        check("hold_tdata", M_AXIS_TDATA, prev_d);
        check("hold_tlast", M_AXIS_TLAST, prev_l);
        check("hold_tvalid", M_AXIS_TVALID, 1'b1);
      end
      if (busy && psum_ready) s_ready_busy++;
      if (!M_AXIS_TVALID && got > 0) s_gaps++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got_data[got] = M_AXIS_TDATA;
        got_last[got] = M_AXIS_TLAST;
        got++;
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_d     = M_AXIS_TDATA;
      prev_l     = M_AXIS_TLAST;
      c++;
      @(negedge clk);
    end
    psum_valid = 1'b0;
    s_cycles   = c;
    if (got < nbeat) check("stream_timeout_beats", got, nbeat);
  endtask

  task automatic check_frame(input string tag, input int off, input logic [23:0] hi, input int base);
    for (int i = 0; i < NB; i++) begin
      check({tag, "_tdata"}, got_data[off+i], word(hi, base, i));
      check({tag, "_tlast"}, got_last[off+i], (i == NB - 1));
    end
  endtask

  task automatic send_one(input logic [PW-1:0] f);
    psum_in    = f;
    psum_valid = 1'b1;
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  initial begin
    f1 = mk(24'h000000, 1);
    fa = mk(24'hA5A5A5, 0);
    fb = mk(24'h5A5A5A, 0);

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tvalid", M_AXIS_TVALID, 1'b0);
    check("rst_tlast", M_AXIS_TLAST, 1'b0);
    check("rst_tdata", M_AXIS_TDATA, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_count", frame_count, 16'h0);
    check("rst_psum_ready", psum_ready, 1'b1);
    check("tstrb", M_AXIS_TSTRB, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    check("idle_psum_ready", psum_ready, 1'b1);

    // Single frame, word k = k+1, full throughput
    M_AXIS_TREADY = 1'b1;
    send_one(f1);
    check("lat_tvalid", M_AXIS_TVALID, 1'b1);
    check("lat_tdata", M_AXIS_TDATA, 32'd1);
    check("lat_busy", busy, 1'b1);
`ifdef PSUM_TX_DOUBLE_BUFFER_EN
    check("send_psum_ready", psum_ready, 1'b1);
`else
    check("send_psum_ready", psum_ready, 1'b0);
`endif
    stream(NB, 1'b0, 1'b0, '0);
    check("single_cycles", s_cycles, NB);
    check("single_gaps", s_gaps, 0);
    check_frame("single", 0, 24'h0, 1);
    check("single_end_tvalid", M_AXIS_TVALID, 1'b0);
    check("single_end_busy", busy, 1'b0);
    check("single_frame_count", frame_count, 16'd1);

    // Backpressure: TREADY low every other cycle
    send_one(f1);
    stream(NB, 1'b1, 1'b0, '0);
    check("bp_cycles", s_cycles, 2 * NB);
    check_frame("bp", 0, 24'h0, 1);
    check("bp_frame_count", frame_count, 16'd2);

    // Back-to-back frames A then B
    M_AXIS_TREADY = 1'b1;
    send_one(fa);
    stream(2 * NB, 1'b0, 1'b1, fb);
    check_frame("b2b_a", 0, 24'hA5A5A5, 0);
    check_frame("b2b_b", NB, 24'h5A5A5A, 0);
`ifdef PSUM_TX_DOUBLE_BUFFER_EN
    check("b2b_gaps", s_gaps, 0);
    check("b2b_cycles", s_cycles, 2 * NB);
`else
    check("b2b_gaps", s_gaps, 1);
    check("b2b_cycles", s_cycles, 2 * NB + 1);
    check("b2b_ready_in_send", s_ready_busy, 0);
`endif
    check("b2b_frame_count", frame_count, 16'd4);

    // Reset at beat 20 aborts the frame
    send_one(f1);
    stream(20, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) check("abort_no_tlast", got_last[i], 1'b0);
    check("abort_beat20_tdata", M_AXIS_TDATA, 32'd21);
    check("abort_beat20_tlast", M_AXIS_TLAST, 1'b0);
    rst        = 1'b1;
    psum_in    = fb;
    psum_valid = 1'b1;
    @(negedge clk);
    check("abort_tvalid", M_AXIS_TVALID, 1'b0);
    check("abort_tlast", M_AXIS_TLAST, 1'b0);
    check("abort_tdata", M_AXIS_TDATA, 32'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_frame_count", frame_count, 16'd0);
    check("abort_psum_ready", psum_ready, 1'b1);
    rst        = 1'b0;
    psum_valid = 1'b0;
    @(negedge clk);
    check("abort_valid_ignored", M_AXIS_TVALID, 1'b0);
    send_one(fa);
    check("restart_tdata", M_AXIS_TDATA, 32'hA5A5A500);
    stream(NB, 1'b0, 1'b0, '0);
    check_frame("restart", 0, 24'hA5A5A5, 0);
    check("restart_frame_count", frame_count, 16'd1);

    // frame_count wrap, preloaded to 0xFFFF
    force dut.frame_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_r;
    @(negedge clk);
    check("wrap_preload", frame_count, 16'hFFFF);
    send_one(f1);
    stream(NB, 1'b0, 1'b0, '0);
    check("wrap_frame_count", frame_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
